// File: rtl/inst_loader.sv
// Byte-stream program loader: parses a length/words/XOR-checksum frame, writes
// each 16-bit word to instruction memory from address 0, and gates cpu_reset.
module inst_loader #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 2048,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic                rx_q, rx_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          chk_q, chk_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         count_q, count_d;
  logic                xfer;
  logic [15:0]         len_w;
  logic [15:0]         count_inc;

  // byte_ready is registered, so a transfer is judged against the current rx_q
  assign xfer      = byte_valid & rx_q;
  assign len_w     = {hi_q, byte_data};
  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_en_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    hi_d        = hi_q;
    chk_d       = chk_q;
    len_d       = len_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          state_d     = S_LEN_HI;
          done_d      = 1'b0;
          error_d     = 1'b0;
          chk_d       = 8'h00;
          count_d     = 16'd0;
          wr_addr_d   = '0;
          cpu_reset_d = 1'b1;
        end
      end
      S_LEN_HI: if (xfer) begin
        state_d = S_LEN_LO;
        hi_d    = byte_data;
        chk_d   = chk_q ^ byte_data;
      end
      S_LEN_LO: if (xfer) begin
        len_d = len_w;
        chk_d = chk_q ^ byte_data;
        if (len_w == 16'd0) begin
          state_d = S_CHECK;
        end else if (len_w > 16'(MAX_WORDS)) begin
          state_d     = S_ERROR;
          error_d     = 1'b1;
          cpu_reset_d = 1'b1;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (xfer) begin
        state_d = S_DATA_LO;
        hi_d    = byte_data;
        chk_d   = chk_q ^ byte_data;
      end
      S_DATA_LO: if (xfer) begin
        wr_en_d   = 1'b1;
        wr_data_d = DATA_W'({hi_q, byte_data});
        chk_d     = chk_q ^ byte_data;
        count_d   = count_inc;
        state_d   = (count_inc == len_q) ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: if (xfer) begin
        if (byte_data == chk_q) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
        end else begin
          state_d     = S_ERROR;
          error_d     = 1'b1;
          cpu_reset_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rx_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA_HI) ||
           (state_d == S_DATA_LO) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= BOOT_HOLD;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      hi_q        <= 8'h00;
      chk_q       <= 8'h00;
      len_q       <= 16'd0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      hi_q        <= hi_d;
      chk_q       <= chk_d;
      len_q       <= len_d;
      count_q     <= count_d;
    end
  end

  assign byte_ready = rx_q;
  assign busy       = rx_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every wr_en pulse.
module tb_inst_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct { logic [10:0] addr; logic [15:0] data; } wr_t;
  wr_t        exp_q[$];
  logic [7:0] frame[$];

  inst_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {21'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {21'd0, wr_addr}, {21'd0, e.addr});
        check("write_data", {16'd0, wr_data}, {16'd0, e.data});
      end
    end
  end

  task automatic expect_wr(input logic [10:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int t;
    if (maxgap > 0) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], maxgap);
  endtask

  task automatic check_flags(input string name, input logic d, input logic e,
                             input logic cr, input logic bz);
    check({name, "_done"},      {31'd0, done},       {31'd0, d});
    check({name, "_error"},     {31'd0, error},      {31'd0, e});
    check({name, "_cpu_reset"}, {31'd0, cpu_reset},  {31'd0, cr});
    check({name, "_busy"},      {31'd0, busy},       {31'd0, bz});
    check({name, "_ready"},     {31'd0, byte_ready}, {31'd0, bz});
  endtask

  task automatic check_reset_vals(input string name);
    check_flags(name, 1'b0, 1'b0, 1'b1, 1'b0);
    check({name, "_wr_en"},   {31'd0, wr_en},   32'd0);
    check({name, "_wr_addr"}, {21'd0, wr_addr}, 32'd0);
    check({name, "_wr_data"}, {16'd0, wr_data}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Two words; checksum 0x56 is the XOR of 00 02 11 23 23 45
    pulse_start();
    check_flags("start", 1'b0, 1'b0, 1'b1, 1'b1);
    expect_wr(11'd0, 16'h1123);
    expect_wr(11'd1, 16'h2345);
    frame = '{8'h00, 8'h02, 8'h11, 8'h23, 8'h23, 8'h45, 8'h56};
    send_frame(0);
    check_flags("two_words", 1'b1, 1'b0, 1'b0, 1'b0);
    check("two_words_addr_after", {21'd0, wr_addr}, 32'd2);

    // Empty image, good then bad checksum
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check_flags("empty_good", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h01};
    send_frame(0);
    check_flags("empty_bad", 1'b0, 1'b1, 1'b1, 1'b0);

    // Oversize length 2049 is rejected straight after the length bytes
    pulse_start();
    frame = '{8'h08, 8'h01};
    send_frame(0);
    check_flags("oversize", 1'b0, 1'b1, 1'b1, 1'b0);
    byte_valid = 1'b1; byte_data = 8'hAA;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check_flags("oversize_idle", 1'b0, 1'b1, 1'b1, 1'b0);

    // Same two-word stream with random valid gaps
    pulse_start();
    expect_wr(11'd0, 16'h1123);
    expect_wr(11'd1, 16'h2345);
    frame = '{8'h00, 8'h02, 8'h11, 8'h23, 8'h23, 8'h45, 8'h56};
    send_frame(3);
    check_flags("gappy", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after the third data byte, then a full reload
    pulse_start();
    expect_wr(11'd0, 16'h1123);
    frame = '{8'h00, 8'h02, 8'h11, 8'h23, 8'h23};
    send_frame(0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midload_reset");
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    expect_wr(11'd0, 16'h1123);
    expect_wr(11'd1, 16'h2345);
    frame = '{8'h00, 8'h02, 8'h11, 8'h23, 8'h23, 8'h45, 8'h56};
    send_frame(0);
    check_flags("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // load_start mid-load has no effect
    pulse_start();
    expect_wr(11'd0, 16'h1123);
    expect_wr(11'd1, 16'h2345);
    frame = '{8'h00, 8'h02, 8'h11};
    send_frame(0);
    pulse_start();
    frame = '{8'h23, 8'h23, 8'h45, 8'h56};
    send_frame(0);
    check_flags("start_ignored", 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad checksum after writes, then a clean restart from address 0
    pulse_start();
    expect_wr(11'd0, 16'h1123);
    expect_wr(11'd1, 16'h2345);
    frame = '{8'h00, 8'h02, 8'h11, 8'h23, 8'h23, 8'h45, 8'h24};
    send_frame(0);
    check_flags("bad_chk", 1'b0, 1'b1, 1'b1, 1'b0);
    check("bad_chk_addr", {21'd0, wr_addr}, 32'd2);
    pulse_start();
    check_flags("restart", 1'b0, 1'b0, 1'b1, 1'b1);
    check("restart_addr", {21'd0, wr_addr}, 32'd0);
    expect_wr(11'd0, 16'hA1B2);
    frame = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'h12};
    send_frame(1);
    check_flags("restart_done", 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("pending_writes", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
